// File: rtl/synchronization_pkg.sv
// Shared definitions for the 1000BASE-X PCS code-group synchronization block:
// FSM states, K28.5 comma patterns and the legal 8b/10b sub-block tables.
package synchronization_pkg;

   typedef enum logic [3:0] {
      LOSS_OF_SYNC,
      COMMA_DETECT_1,
      COMMA_DETECT_2,
      COMMA_DETECT_3,
      ACQUIRE_SYNC_1,
      ACQUIRE_SYNC_2,
      SYNC_ACQUIRED_1,
      SYNC_ACQUIRED_2,
      SYNC_ACQUIRED_2A,
      SYNC_ACQUIRED_3,
      SYNC_ACQUIRED_3A,
      SYNC_ACQUIRED_4,
      SYNC_ACQUIRED_4A
   } sync_state_t;

   localparam logic [9:0] K28_5_NEG = 10'b0011111010;
   localparam logic [9:0] K28_5_POS = 10'b1100000101;

   // abcdei sub-blocks of D.0-D.31 and K.28, both disparity columns
   function automatic logic legal_6b(input logic [5:0] c);
      case (c)
         6'b100111, 6'b011000, 6'b011101, 6'b100010, 6'b101101, 6'b010010,
         6'b110001, 6'b110101, 6'b001010, 6'b101001, 6'b011001, 6'b111000,
         6'b000111, 6'b111001, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
         6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b101000, 6'b011011,
         6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
         6'b011010, 6'b111010, 6'b000101, 6'b110011, 6'b001100, 6'b100110,
         6'b010110, 6'b110110, 6'b001001, 6'b001110, 6'b101110, 6'b010001,
         6'b011110, 6'b100001, 6'b101011, 6'b010100, 6'b001111, 6'b110000:
            legal_6b = 1'b1;
         default:
            legal_6b = 1'b0;
      endcase
   endfunction

   // fghj sub-blocks of D.x.0-D.x.7 (including the alternate x.A7) and K28.5
   function automatic logic legal_4b(input logic [3:0] c);
      case (c)
         4'b1011, 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b0011, 4'b1101,
         4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0001, 4'b0111, 4'b1000:
            legal_4b = 1'b1;
         default:
            legal_4b = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/synchronization_cg_checker.sv
// Combinational classification of one received code group: comma, valid
// (legal sub-blocks, no running-disparity check) and data (valid non-comma).
module cg_checker
   import synchronization_pkg::*;
(
   input  logic [9:0] cg,
   output logic       comma,
   output logic       valid,
   output logic       is_data
);

   assign comma   = (cg == K28_5_NEG) || (cg == K28_5_POS);
   assign valid   = legal_6b(cg[9:4]) && legal_4b(cg[3:0]);
   assign is_data = valid && !comma;

endmodule

// File: rtl/synchronization.sv
// PCS code-group synchronization FSM: aligns to K28.5 commas, tracks the
// even/odd code-group position and reports code_sync_status.
module synchronization
   import synchronization_pkg::*;
(
   input  logic        Clk,
   input  logic        mr_main_reset,
   input  logic        power_on,
   input  logic [9:0]  PUDI,
   output logic        code_sync_status,
   output logic [10:0] SUDI
);

   sync_state_t state, state_next;
   logic        rx_even, rx_even_next;
   logic        status_next;
   logic [1:0]  good_cgs, good_cgs_next;
   logic        comma, valid, is_data;
   logic        cgbad, cggood;

   function automatic logic is_a_state(input sync_state_t s);
      return (s == SYNC_ACQUIRED_2A) || (s == SYNC_ACQUIRED_3A) ||
             (s == SYNC_ACQUIRED_4A);
   endfunction

   cg_checker u_cg_checker (
      .cg      (PUDI),
      .comma   (comma),
      .valid   (valid),
      .is_data (is_data)
   );

   always_comb begin
      cgbad  = !valid || (comma && rx_even);
      cggood = !cgbad;

      state_next = state;
      case (state)
         LOSS_OF_SYNC:     if (comma) state_next = COMMA_DETECT_1;
         COMMA_DETECT_1:   state_next = is_data ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
         COMMA_DETECT_2:   state_next = is_data ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
         COMMA_DETECT_3:   state_next = is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
         ACQUIRE_SYNC_1: begin
            if (comma && !rx_even) state_next = COMMA_DETECT_2;
            else if (cgbad)        state_next = LOSS_OF_SYNC;
         end
         ACQUIRE_SYNC_2: begin
            if (comma && !rx_even) state_next = COMMA_DETECT_3;
            else if (cgbad)        state_next = LOSS_OF_SYNC;
         end
         SYNC_ACQUIRED_1:  if (cgbad) state_next = SYNC_ACQUIRED_2;
         SYNC_ACQUIRED_2:  state_next = cggood ? SYNC_ACQUIRED_2A : SYNC_ACQUIRED_3;
         SYNC_ACQUIRED_3:  state_next = cggood ? SYNC_ACQUIRED_3A : SYNC_ACQUIRED_4;
         SYNC_ACQUIRED_4:  state_next = cggood ? SYNC_ACQUIRED_4A : LOSS_OF_SYNC;
         // good_cgs==2 here means this good group is the third in a row
         SYNC_ACQUIRED_2A: begin
            if (cgbad)                  state_next = SYNC_ACQUIRED_3;
            else if (good_cgs == 2'd2)  state_next = SYNC_ACQUIRED_1;
         end
         SYNC_ACQUIRED_3A: begin
            if (cgbad)                  state_next = SYNC_ACQUIRED_4;
            else if (good_cgs == 2'd2)  state_next = SYNC_ACQUIRED_2;
         end
         SYNC_ACQUIRED_4A: begin
            if (cgbad)                  state_next = LOSS_OF_SYNC;
            else if (good_cgs == 2'd2)  state_next = SYNC_ACQUIRED_3;
         end
         default:          state_next = LOSS_OF_SYNC;
      endcase
      if (power_on) state_next = LOSS_OF_SYNC;

      // registered outputs reflect the state being entered on this edge
      rx_even_next  = !rx_even;
      status_next   = 1'b0;
      good_cgs_next = 2'd0;
      case (state_next)
         COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3:
            rx_even_next = 1'b1;
         SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4:
            status_next = 1'b1;
         SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
            status_next   = 1'b1;
            good_cgs_next = is_a_state(state) ? good_cgs + 2'd1 : 2'd1;
         end
         default: ;
      endcase
      if (power_on) rx_even_next = 1'b0;
   end

   always_ff @(posedge Clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         state            <= LOSS_OF_SYNC;
         rx_even          <= 1'b0;
         good_cgs         <= 2'd0;
         code_sync_status <= 1'b0;
         SUDI             <= 11'd0;
      end else begin
         state            <= state_next;
         rx_even          <= rx_even_next;
         good_cgs         <= good_cgs_next;
         code_sync_status <= status_next;
         SUDI             <= {rx_even_next, PUDI};
      end
   end

endmodule

// File: tb/tb_synchronization.sv
// Directed bench for the code-group synchronization FSM.
module tb_synchronization;
   import synchronization_pkg::*;

   localparam logic [9:0] D16_2 = 10'b1001000101;
   localparam logic [9:0] BAD   = 10'b0000000000;

   logic        Clk = 1'b0;
   logic        mr_main_reset;
   logic        power_on;
   logic [9:0]  PUDI;
   logic        code_sync_status;
   logic [10:0] SUDI;

   int compared   = 0;
   int mismatched = 0;

   always #5 Clk = ~Clk;

   synchronization dut (
      .Clk              (Clk),
      .mr_main_reset    (mr_main_reset),
      .power_on         (power_on),
      .PUDI             (PUDI),
      .code_sync_status (code_sync_status),
      .SUDI             (SUDI)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [9:0] cg);
      PUDI = cg;
      @(posedge Clk);
      #1;
   endtask

   // comma on even positions, D16.2 on odd; sync is declared on the sixth edge
   task automatic acquire(input string tag);
      logic [9:0] cg;
      logic       even_exp;
      logic       sts_exp;
      for (int i = 0; i < 6; i++) begin
         cg       = (i % 2 == 0) ? K28_5_NEG : D16_2;
         even_exp = (i % 2 == 0);
         sts_exp  = (i == 5);
         step(cg);
         check($sformatf("%s_rxeven%0d", tag, i), 32'(SUDI[10]), 32'(even_exp));
         check($sformatf("%s_status%0d", tag, i), 32'(code_sync_status), 32'(sts_exp));
      end
      check({tag, "_sudi"}, 32'(SUDI[9:0]), 32'(D16_2));
      check({tag, "_state"}, 32'(dut.state), 32'(SYNC_ACQUIRED_1));
   endtask

   initial begin
      mr_main_reset = 1'b1;
      power_on      = 1'b0;
      PUDI          = 10'd0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_status", 32'(code_sync_status), 32'd0);
      check("rst_sudi", 32'(SUDI), 32'd0);
      check("rst_state", 32'(dut.state), 32'(LOSS_OF_SYNC));
      mr_main_reset = 1'b0;

      acquire("acq");

      // four invalid groups in a row lose sync on the fourth
      for (int i = 0; i < 4; i++) begin
         step(BAD);
         check($sformatf("loss_status%0d", i), 32'(code_sync_status), (i < 3) ? 32'd1 : 32'd0);
      end
      check("loss_state", 32'(dut.state), 32'(LOSS_OF_SYNC));

      acquire("reacq1");

      // one bad group, then three good groups climb back to SYNC_ACQUIRED_1
      step(BAD);
      check("rec_status0", 32'(code_sync_status), 32'd1);
      check("rec_state0", 32'(dut.state), 32'(SYNC_ACQUIRED_2));
      step(D16_2);
      check("rec_status1", 32'(code_sync_status), 32'd1);
      check("rec_state1", 32'(dut.state), 32'(SYNC_ACQUIRED_2A));
      step(K28_5_POS);
      check("rec_status2", 32'(code_sync_status), 32'd1);
      check("rec_state2", 32'(dut.state), 32'(SYNC_ACQUIRED_2A));
      step(D16_2);
      check("rec_status3", 32'(code_sync_status), 32'd1);
      check("rec_state3", 32'(dut.state), 32'(SYNC_ACQUIRED_1));

      // comma arriving on an odd position during acquisition
      mr_main_reset = 1'b1;
      @(posedge Clk);
      #1;
      mr_main_reset = 1'b0;
      step(K28_5_NEG);
      check("odd_state0", 32'(dut.state), 32'(COMMA_DETECT_1));
      step(D16_2);
      check("odd_state1", 32'(dut.state), 32'(ACQUIRE_SYNC_1));
      step(D16_2);
      check("odd_state2", 32'(dut.state), 32'(ACQUIRE_SYNC_1));
      check("odd_rxeven2", 32'(SUDI[10]), 32'd1);
      step(K28_5_NEG);
      check("odd_state3", 32'(dut.state), 32'(LOSS_OF_SYNC));
      check("odd_status3", 32'(code_sync_status), 32'd0);

      acquire("reacq2");

      // asynchronous reset pulse between clock edges
      #2;
      mr_main_reset = 1'b1;
      #1;
      check("async_status", 32'(code_sync_status), 32'd0);
      check("async_sudi", 32'(SUDI), 32'd0);
      check("async_state", 32'(dut.state), 32'(LOSS_OF_SYNC));
      #1;
      mr_main_reset = 1'b0;

      // comma followed by a non-data group falls back out of COMMA_DETECT_1
      step(K28_5_NEG);
      check("cd1_state", 32'(dut.state), 32'(COMMA_DETECT_1));
      step(K28_5_POS);
      check("cd1_fail_state", 32'(dut.state), 32'(LOSS_OF_SYNC));

      acquire("reacq3");

      // one-cycle power_on while synced
      power_on = 1'b1;
      step(D16_2);
      power_on = 1'b0;
      check("pwr_status", 32'(code_sync_status), 32'd0);
      check("pwr_sudi", 32'(SUDI), 32'({1'b0, D16_2}));
      check("pwr_state", 32'(dut.state), 32'(LOSS_OF_SYNC));

      acquire("reacq4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
